eth_payload_dispatcher: RTL and testbench
=========================================

# eth_payload_dispatcher

Parametrised payload-stage dispatcher between the Ethernet frame parser and the per-protocol handlers (IPv4, ARP, …). It routes the payload byte stream to one of `NUM_HANDLERS` handlers by EtherType, reports frame completion, and discards unknown types. It also collects transmit requests from all handlers into a round-robin-arbitrated TX queue with a valid/ready output, so no handler's packet is lost when several request in the same cycle.

## Interface
Parameters:
- `NUM_HANDLERS`, 2: number of handler channels (1–8).
- `HANDLER_TYPES`, `{16'h0806, 16'h0800}`: packed `NUM_HANDLERS*16` EtherType table; slice k selects channel k.
- `TX_QUEUE_DEPTH`, 2: TX FIFO entries, power of two, ≥2.

Ports (one clock `eth_clk`; `rst_in` synchronous, active-high):
- `eth_clk` in 1: 50 MHz clock.
- `rst_in` in 1: synchronous active-high reset.
- `active` in 1: high during the payload segment.
- `eth_header` in `st_eth_header`: header; stable while `active`.
- `data_rxd` in 8: decoded byte, forwarded to handlers externally.
- `data_new` in 1: `data_rxd` valid strobe, forwarded to handlers externally.
- `hdl_active` out `NUM_HANDLERS`: per-handler enable.
- `hdl_finished` in `NUM_HANDLERS`: per-handler finished.
- `hdl_send_packet` in `NUM_HANDLERS`: per-handler one-cycle TX request.
- `hdl_eth_packet` in `st_eth_packet [NUM_HANDLERS]`: packets, valid with the request.
- `finished` out 1: payload handling complete.
- `send_packet` out 1: TX queue head valid.
- `eth_packet` out `st_eth_packet`: TX queue head.
- `tx_ready` in 1: downstream accepts the head.
- `unknown_count` out 16: frames with unmatched EtherType (saturating).
- `tx_drop_count` out 16: dropped TX requests (saturating).

## Operation
- Match: `match[k] = (eth_header.ether_type == HANDLER_TYPES[k])`. On duplicate entries, the lowest index wins (one-hot after priority).
- `hdl_active[k] = active & match_onehot[k]` is combinational, so the first payload byte is not lost.
- FSM states: IDLE, ROUTE, DISCARD.
  - From IDLE, when `active`: go to ROUTE and latch `sel` if any match; otherwise go to DISCARD and increment `unknown_count`.
  - From ROUTE or DISCARD, go to IDLE when `!active`.
- `finished` by state:
  - IDLE: 0.
  - ROUTE: `hdl_finished[sel]`.
  - DISCARD: 1.
  - In the first `active` cycle while still in IDLE, `finished` follows the combinational decode (1 if unmatched).
- TX capture: each channel has a one-entry pending register. On `hdl_send_packet[k]`, the packet is written to pending k and `pend[k]` is set.
  - If `pend[k]` is already set and is not being granted in that cycle, the new request is dropped and `tx_drop_count` increments.
- Arbitration: round-robin over `pend`. One grant per cycle, only when the FIFO is not full. The grant clears `pend[k]` and pushes into the FIFO. The pointer advances to `granted+1` mod N.
- FIFO: `send_packet = !empty`, `eth_packet = head`; pop when `send_packet & tx_ready`.
  - Push and pop in the same cycle while full is allowed.
  - When full, no grant is made and pending entries are held (back-pressure only; no drop).
- Counters saturate at 16'hFFFF; a saturated counter holds its value.

## Timing
- Reset values: FSM IDLE, `pend`=0, FIFO empty, arbiter pointer 0, `send_packet`=0, `eth_packet`=0, `finished`=0, both counters 0.
- Reset mid-frame or mid-queue discards everything; no partial packet is emitted.
- TX latency:
  - Request sampled at edge t.
  - Granted and pushed at edge t+1.
  - `send_packet`=1 in cycle t+2, provided the FIFO was empty and the channel won arbitration.
- Simultaneous requests on N channels reach the FIFO over N consecutive cycles.
- `hdl_active` and `finished` in ROUTE/DISCARD are zero-latency combinational paths. State changes are registered.
- The FSM, pending registers and FIFO are independent, so TX draining continues across frame boundaries.

## Configuration
- `ETH_DISPATCH_STATS_EN`:
  - Defined: `unknown_count` and `tx_drop_count` registers are implemented as specified.
  - Undefined: both outputs are tied to 0, their registers are removed, and drop behaviour is otherwise unchanged.

## Structure
- `Types` package additions: `e_dispatch_state` enum (IDLE, ROUTE, DISCARD) and the `DEFAULT_HANDLER_TYPES` constant. `st_eth_header` and `st_eth_packet` are reused from `Types`.
- Sub-module `eth_tx_rr_arbiter`:
  - Parameter: `NUM_HANDLERS`.
  - Inputs: `pend`, `fifo_full`.
  - Outputs: `grant_valid`, `grant_idx`.
  - Holds the round-robin pointer internally.
- The FIFO is inline (array plus read/write pointers and count).

## Test plan
- Unmatched type: EtherType 0x86DD, `active` for 10 cycles → `hdl_active`=0, `finished`=1 from the first active cycle, `unknown_count` increments 0→1 once.
- ARP routing: EtherType 0x0806, `hdl_finished[0]` asserted on the 28th `data_new` → `hdl_active`=2'b01 throughout, `finished` follows `hdl_finished[0]`, returns to 0 after `active` falls.
- Simultaneous requests: both channels pulse in the same cycle with `tx_ready`=1 → ch0 packet emitted in cycle t+2, ch1 in t+3, no drops; the next simultaneous pair emits ch1 first (round-robin advance).
- Back-pressure: `tx_ready`=0, three requests from ch0 spaced 1 apart with depth 2 → two queued, third held pending, a fourth request is dropped (`tx_drop_count`=1); raising `tx_ready` drains three packets in order.
- Reset mid-operation: assert `rst_in` with FIFO holding 2 packets and FSM in ROUTE → next cycle `send_packet`=0, FSM IDLE, counters 0.
- Stats compiled out: rerun the back-pressure case without `ETH_DISPATCH_STATS_EN` → same packet sequence, `tx_drop_count`=0.

Source files
------------

// File: rtl/eth_payload_dispatcher_pkg.sv
// Shared types for the Ethernet payload dispatcher: header/packet structs,
// the dispatcher FSM state enum, the default EtherType table and a
// saturating-add helper used by the statistics counters.
package Types;

   typedef struct packed {
      logic [47:0] dst_mac;
      logic [47:0] src_mac;
      logic [15:0] ether_type;
   } st_eth_header;

   typedef struct packed {
      st_eth_header header;
      logic [15:0]  length;
      logic [15:0]  payload_id;
   } st_eth_packet;

   typedef enum logic [1:0] {
      IDLE,
      ROUTE,
      DISCARD
   } e_dispatch_state;

   // Written in channel order: the leftmost entry belongs to channel 0 (ARP),
   // the next one to channel 1 (IPv4).
   localparam logic [31:0] DEFAULT_HANDLER_TYPES = {16'h0806, 16'h0800};

   // 16-bit add that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_add16(input logic [15:0] v, input logic [3:0] inc);
      logic [16:0] s;
      s = {1'b0, v} + 17'(inc);
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

endpackage

// File: rtl/eth_payload_dispatcher_tx_arb.sv
// Round-robin arbiter for the TX pending registers. One grant per cycle,
// suppressed while the TX FIFO cannot take an entry. The search starts at
// the pointer and the pointer moves to the slot after the winner.
module eth_tx_rr_arbiter #(
   parameter int NUM_HANDLERS = 2,
   localparam int IDX_W = (NUM_HANDLERS > 1) ? $clog2(NUM_HANDLERS) : 1
) (
   input  logic                    eth_clk,
   input  logic                    rst_in,
   input  logic [NUM_HANDLERS-1:0] pend,
   input  logic                    fifo_full,
   output logic                    grant_valid,
   output logic [IDX_W-1:0]        grant_idx
);

   logic [IDX_W-1:0] ptr_q, ptr_d;

   // Pick the first pending channel at or after the pointer, wrapping around.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < NUM_HANDLERS; i++) begin
         if (!grant_valid && !fifo_full && pend[(int'(ptr_q) + i) % NUM_HANDLERS]) begin
            grant_valid = 1'b1;
            grant_idx   = IDX_W'((int'(ptr_q) + i) % NUM_HANDLERS);
         end
      end
      ptr_d = ptr_q;
      if (grant_valid) begin
         ptr_d = (int'(grant_idx) == NUM_HANDLERS - 1) ? '0 : grant_idx + 1'b1;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge eth_clk) begin
      if (rst_in) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/eth_payload_dispatcher.sv
// Payload-stage dispatcher: routes the payload to one handler by EtherType,
// reports frame completion, discards unknown types, and merges handler TX
// requests through per-channel pending registers, a round-robin arbiter and
// a small TX FIFO.
// Optional feature macro: ETH_DISPATCH_STATS_EN (unknown/drop counters).
module eth_payload_dispatcher
   import Types::*;
#(
   parameter int                          NUM_HANDLERS   = 2,
   parameter logic [NUM_HANDLERS*16-1:0]  HANDLER_TYPES  = DEFAULT_HANDLER_TYPES,
   parameter int                          TX_QUEUE_DEPTH = 2
) (
   input  logic                    eth_clk,
   input  logic                    rst_in,
   input  logic                    active,
   input  st_eth_header            eth_header,
   input  logic [7:0]              data_rxd,
   input  logic                    data_new,
   output logic [NUM_HANDLERS-1:0] hdl_active,
   input  logic [NUM_HANDLERS-1:0] hdl_finished,
   input  logic [NUM_HANDLERS-1:0] hdl_send_packet,
   input  st_eth_packet            hdl_eth_packet [NUM_HANDLERS],
   output logic                    finished,
   output logic                    send_packet,
   output st_eth_packet            eth_packet,
   input  logic                    tx_ready,
   output logic [15:0]             unknown_count,
   output logic [15:0]             tx_drop_count
);

   localparam int IDX_W = (NUM_HANDLERS > 1) ? $clog2(NUM_HANDLERS) : 1;
   localparam int PTR_W = $clog2(TX_QUEUE_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // The byte stream goes to the handlers outside this block; only the
   // EtherType of the header is used here.
   logic unused_inputs;
   assign unused_inputs = ^{data_rxd, data_new, eth_header};

   // ---------------- EtherType decode ----------------
   logic [NUM_HANDLERS-1:0] match, match_onehot;
   logic [IDX_W-1:0]        match_idx;
   logic                    any_match;

   for (genvar gi = 0; gi < NUM_HANDLERS; gi++) begin : g_match
      assign match[gi] = (eth_header.ether_type == HANDLER_TYPES[(NUM_HANDLERS-1-gi)*16 +: 16]);
   end

   // Lowest matching index wins when the table has duplicates.
   always_comb begin
      match_onehot = '0;
      match_idx    = '0;
      for (int k = 0; k < NUM_HANDLERS; k++) begin
         if (match[k] && (match_onehot == '0)) begin
            match_onehot[k] = 1'b1;
            match_idx       = IDX_W'(k);
         end
      end
   end

   assign any_match  = |match;
   assign hdl_active = {NUM_HANDLERS{active}} & match_onehot;

   // ---------------- Frame FSM ----------------
   e_dispatch_state  state_q, state_d;
   logic [IDX_W-1:0] sel_q, sel_d;

   // Next state, latched channel and combinational finished.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      finished = 1'b0;
      case (state_q)
         IDLE: begin
            if (active) begin
               finished = !any_match;
               if (any_match) begin
                  state_d = ROUTE;
                  sel_d   = match_idx;
               end else begin
                  state_d = DISCARD;
               end
            end
         end
         ROUTE: begin
            finished = hdl_finished[sel_q];
            if (!active) state_d = IDLE;
         end
         DISCARD: begin
            finished = 1'b1;
            if (!active) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state and selected channel registers.
   always_ff @(posedge eth_clk) begin
      if (rst_in) begin
         state_q <= IDLE;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
      end
   end

   // ---------------- TX pending registers ----------------
   logic [NUM_HANDLERS-1:0] pend_q, granted, accept;
   st_eth_packet            pend_pkt_q [NUM_HANDLERS];
   logic                    grant_valid;
   logic [IDX_W-1:0]        grant_idx;
   logic                    push, pop, fifo_full;

   // A request is taken when its slot is free or is being emptied this cycle.
   for (genvar gi = 0; gi < NUM_HANDLERS; gi++) begin : g_pend
      assign granted[gi] = grant_valid && (grant_idx == IDX_W'(gi));
      assign accept[gi]  = hdl_send_packet[gi] && !(pend_q[gi] && !granted[gi]);
   end

   // Pending flags: a new request wins over the clear from a grant.
   always_ff @(posedge eth_clk) begin
      if (rst_in) begin
         pend_q <= '0;
      end else begin
         for (int k = 0; k < NUM_HANDLERS; k++) begin
            if (accept[k])       pend_q[k] <= 1'b1;
            else if (granted[k]) pend_q[k] <= 1'b0;
         end
      end
   end

   // Pending packet payloads; only meaningful while the flag is set.
   always_ff @(posedge eth_clk) begin
      for (int k = 0; k < NUM_HANDLERS; k++) begin
         if (accept[k]) pend_pkt_q[k] <= hdl_eth_packet[k];
      end
   end

   eth_tx_rr_arbiter #(.NUM_HANDLERS(NUM_HANDLERS)) u_arb (
      .eth_clk     (eth_clk),
      .rst_in      (rst_in),
      .pend        (pend_q),
      .fifo_full   (fifo_full),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // ---------------- TX FIFO ----------------
   st_eth_packet     mem_q [TX_QUEUE_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;

   assign send_packet = (count_q != '0);
   assign eth_packet  = send_packet ? mem_q[rd_ptr_q] : '0;
   assign pop         = send_packet && tx_ready;
   assign push        = grant_valid;
   // A full FIFO still accepts a push in the cycle its head leaves.
   assign fifo_full   = (count_q == CNT_W'(TX_QUEUE_DEPTH)) && !pop;

   // FIFO storage write.
   always_ff @(posedge eth_clk) begin
      if (push) mem_q[wr_ptr_q] <= pend_pkt_q[grant_idx];
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge eth_clk) begin
      if (rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // ---------------- Statistics ----------------
`ifdef ETH_DISPATCH_STATS_EN
   logic [15:0]             unknown_q, drop_q;
   logic [NUM_HANDLERS-1:0] drop_vec;
   logic                    unknown_inc;

   assign drop_vec    = hdl_send_packet & pend_q & ~granted;
   assign unknown_inc = (state_q == IDLE) && active && !any_match;

   // Saturating counters of discarded frames and dropped TX requests.
   always_ff @(posedge eth_clk) begin
      if (rst_in) begin
         unknown_q <= '0;
         drop_q    <= '0;
      end else begin
         unknown_q <= sat_add16(unknown_q, 4'(unknown_inc));
         drop_q    <= sat_add16(drop_q, 4'($countones(drop_vec)));
      end
   end

   assign unknown_count = unknown_q;
   assign tx_drop_count = drop_q;
`else
   assign unknown_count = '0;
   assign tx_drop_count = '0;
`endif

endmodule

// File: tb/tb_eth_payload_dispatcher.sv
// Scoreboard bench for eth_payload_dispatcher: expected TX packets are queued
// at issue time and a negedge monitor compares every accepted head.
// Counter expectations follow ETH_DISPATCH_STATS_EN.
module tb_eth_payload_dispatcher;
   import Types::*;

   localparam int N = 2;
`ifdef ETH_DISPATCH_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          eth_clk = 1'b0;
   logic          rst_in;
   logic          active;
   st_eth_header  eth_header;
   logic [7:0]    data_rxd;
   logic          data_new;
   logic [N-1:0]  hdl_active;
   logic [N-1:0]  hdl_finished;
   logic [N-1:0]  hdl_send_packet;
   st_eth_packet  hdl_eth_packet [N];
   logic          finished;
   logic          send_packet;
   st_eth_packet  eth_packet;
   logic          tx_ready;
   logic [15:0]   unknown_count;
   logic [15:0]   tx_drop_count;

   int checks   = 0;
   int failures = 0;
   st_eth_packet exp_q [$];
   st_eth_packet mon_exp;

   always #5 eth_clk = ~eth_clk;

   eth_payload_dispatcher #(
      .NUM_HANDLERS   (N),
      .HANDLER_TYPES  ({16'h0806, 16'h0800}),
      .TX_QUEUE_DEPTH (2)
   ) dut (
      .eth_clk         (eth_clk),
      .rst_in          (rst_in),
      .active          (active),
      .eth_header      (eth_header),
      .data_rxd        (data_rxd),
      .data_new        (data_new),
      .hdl_active      (hdl_active),
      .hdl_finished    (hdl_finished),
      .hdl_send_packet (hdl_send_packet),
      .hdl_eth_packet  (hdl_eth_packet),
      .finished        (finished),
      .send_packet     (send_packet),
      .eth_packet      (eth_packet),
      .tx_ready        (tx_ready),
      .unknown_count   (unknown_count),
      .tx_drop_count   (tx_drop_count)
   );

   function automatic st_eth_packet mk_pkt(input logic [15:0] id);
      st_eth_packet p;
      p = '0;
      p.header.dst_mac    = 48'hFFFF_FFFF_FFFF;
      p.header.src_mac    = {32'h0200_0000, id};
      p.header.ether_type = 16'h0806;
      p.length            = id ^ 16'h00FF;
      p.payload_id        = id;
      return p;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge eth_clk);
      #1;
   endtask

   task automatic sample();
      @(negedge eth_clk);
   endtask

   task automatic set_type(input logic [15:0] t);
      eth_header = '0;
      eth_header.dst_mac    = 48'h0200_0000_0001;
      eth_header.src_mac    = 48'h0200_0000_0002;
      eth_header.ether_type = t;
   endtask

   // Scoreboard monitor: every accepted head must match the oldest expectation.
   always @(negedge eth_clk) begin
      if (!rst_in && send_packet && tx_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL tx_unexpected actual_id=%0h required=none", eth_packet.payload_id);
         end else begin
            mon_exp = exp_q.pop_front();
            if (eth_packet !== mon_exp) begin
               failures++;
               $display("FAIL tx_packet actual_id=%0h required_id=%0h", eth_packet.payload_id, mon_exp.payload_id);
            end else begin
               $display("TX packet id=%0h", eth_packet.payload_id);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      rst_in = 1'b1;
      active = 1'b0;
      set_type(16'h0000);
      data_rxd = '0;
      data_new = 1'b0;
      hdl_finished = '0;
      hdl_send_packet = '0;
      for (int k = 0; k < N; k++) hdl_eth_packet[k] = '0;
      tx_ready = 1'b1;
      step(); step();
      rst_in = 1'b0;

      // Reset state
      sample();
      chk("rst_send_packet", send_packet, 0);
      chk("rst_eth_packet", eth_packet, 0);
      chk("rst_finished", finished, 0);
      chk("rst_unknown", unknown_count, 0);
      chk("rst_drop", tx_drop_count, 0);
      step();

      // Unmatched EtherType
      set_type(16'h86DD);
      active = 1'b1;
      for (int i = 0; i < 10; i++) begin
         sample();
         chk("unk_hdl_active", hdl_active, 2'b00);
         chk("unk_finished", finished, 1);
         step();
      end
      active = 1'b0;
      step();
      sample();
      chk("unk_finished_idle", finished, 0);
      chk("unk_count", unknown_count, STATS ? 16'd1 : 16'd0);
      $display("FRAME unknown 0x86DD done");
      step();

      // ARP routing
      set_type(16'h0806);
      active = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         data_new = 1'b1;
         data_rxd = 8'(i);
         hdl_finished = (i >= 28) ? 2'b01 : 2'b00;
         sample();
         chk("arp_hdl_active", hdl_active, 2'b01);
         chk("arp_finished", finished, (i >= 28) ? 1 : 0);
         step();
      end
      active = 1'b0;
      data_new = 1'b0;
      hdl_finished = '0;
      sample();
      chk("arp_hdl_active_off", hdl_active, 2'b00);
      chk("arp_finished_off", finished, 0);
      step();
      sample();
      chk("arp_finished_idle", finished, 0);
      $display("FRAME arp 0x0806 done");
      step();

      // IPv4 routing: finished must follow channel 1, not channel 0
      set_type(16'h0800);
      active = 1'b1;
      for (int i = 0; i < 4; i++) begin
         hdl_finished = (i < 2) ? 2'b01 : 2'b10;
         sample();
         chk("ipv4_hdl_active", hdl_active, 2'b10);
         chk("ipv4_finished", finished, (i < 2) ? 0 : 1);
         step();
      end
      active = 1'b0;
      hdl_finished = '0;
      step();
      $display("FRAME ipv4 0x0800 done");

      // Simultaneous requests, then pointer advance
      tx_ready = 1'b1;
      hdl_send_packet = 2'b11;
      hdl_eth_packet[0] = mk_pkt(16'h0101);
      hdl_eth_packet[1] = mk_pkt(16'h0102);
      exp_q.push_back(mk_pkt(16'h0101));
      exp_q.push_back(mk_pkt(16'h0102));
      step();
      hdl_send_packet = '0;
      sample();
      chk("lat_t1_send", send_packet, 0);
      step();
      sample();
      chk("lat_t2_send", send_packet, 1);
      chk("lat_t2_id", eth_packet.payload_id, 16'h0101);
      step();
      sample();
      chk("lat_t3_id", eth_packet.payload_id, 16'h0102);
      step(); step();

      hdl_send_packet = 2'b01;
      hdl_eth_packet[0] = mk_pkt(16'h0103);
      exp_q.push_back(mk_pkt(16'h0103));
      step();
      hdl_send_packet = '0;
      step(); step(); step();

      hdl_send_packet = 2'b11;
      hdl_eth_packet[0] = mk_pkt(16'h0104);
      hdl_eth_packet[1] = mk_pkt(16'h0105);
      exp_q.push_back(mk_pkt(16'h0105));
      exp_q.push_back(mk_pkt(16'h0104));
      step();
      hdl_send_packet = '0;
      step();
      sample();
      chk("rr_first_id", eth_packet.payload_id, 16'h0105);
      step(); step(); step();
      chk("pair_drained", exp_q.size(), 0);
      chk("pair_no_drop", tx_drop_count, 0);

      // Back-pressure: 3 queued/held, 4th dropped
      tx_ready = 1'b0;
      for (int j = 0; j < 4; j++) begin
         hdl_send_packet = 2'b01;
         hdl_eth_packet[0] = mk_pkt(16'h0201 + 16'(j));
         if (j < 3) exp_q.push_back(mk_pkt(16'h0201 + 16'(j)));
         step();
         hdl_send_packet = '0;
         step();
      end
      sample();
      chk("bp_drop", tx_drop_count, STATS ? 16'd1 : 16'd0);
      chk("bp_send", send_packet, 1);
      chk("bp_head_id", eth_packet.payload_id, 16'h0201);
      step();
      tx_ready = 1'b1;
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
      chk("bp_drained", exp_q.size(), 0);
      step();
      sample();
      chk("bp_empty", send_packet, 0);
      step();

      // Reset with FIFO holding 2 packets and FSM in ROUTE
      tx_ready = 1'b0;
      set_type(16'h0806);
      active = 1'b1;
      hdl_finished = 2'b01;
      for (int j = 0; j < 2; j++) begin
         hdl_send_packet = 2'b01;
         hdl_eth_packet[0] = mk_pkt(16'h0301 + 16'(j));
         step();
         hdl_send_packet = '0;
         step();
      end
      sample();
      chk("pre_rst_route_finished", finished, 1);
      chk("pre_rst_send", send_packet, 1);
      step();
      rst_in = 1'b1;
      step();
      sample();
      chk("mid_rst_send", send_packet, 0);
      chk("mid_rst_finished_idle", finished, 0);
      chk("mid_rst_unknown", unknown_count, 0);
      chk("mid_rst_drop", tx_drop_count, 0);
      step();
      rst_in = 1'b0;
      active = 1'b0;
      hdl_finished = '0;
      tx_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sample();
         chk("post_rst_send", send_packet, 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
